stu_copy_responder: RTL
=======================

# stu_copy_responder

Core-side endpoint of the STU context-copy bus, one instance per core. When its core is master, it serves register reads for the STU context manager through a spare register-file read port. When its core is the L2 speculative target, it accepts register writes into a small FIFO and drains them into the register-file write port around the core's own writeback traffic. It reports when the full architectural context (x1..x31) has landed.

## Interface
- CORE_ID, 0: index of this core in `stu_pkg::NUM_CORES`. Selects its bit of the write-enable vector at the top level.
- XLEN, 64: register width; matches `stu_pkg::reg_width_t`.
- FIFO_DEPTH, 4: write-FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- copy_start_in  in  1  one-cycle pulse; a new copy is beginning.
- squash_in  in  1  this core's squash bit.
- is_master_in  in  1  this core is the current master (copy source).
- copy_read_addr_in  in  5  register index requested by the STU.
- copy_data_out  out  XLEN  read data to the STU. Zero when not master, so the top level can OR-reduce across cores.
- copy_write_addr_in  in  5  destination register index.
- copy_write_en_in  in  1  this core's write-enable bit.
- copy_data_in  in  XLEN  write data from the STU.
- rf_rd_addr_out  out  5  spare read-port address.
- rf_rd_data_in  in  XLEN  spare read-port data; combinational from rf_rd_addr_out.
- core_wb_busy_in  in  1  the core's writeback owns the RF write port this cycle.
- rf_wr_en_out  out  1  RF write strobe.
- rf_wr_addr_out  out  5  RF write index.
- rf_wr_data_out  out  XLEN  RF write data.
- fifo_full_out  out  1  FIFO holds FIFO_DEPTH entries.
- overflow_out  out  1  sticky: a write was dropped.
- loaded_mask_out  out  32  bit i set once xi has been written to the RF; bit 0 is hardwired 1.
- context_loaded_out  out  1  state is LOADED.

## Operation
- FSM states: IDLE, LOADING, LOADED.
  - IDLE→LOADING on copy_start_in.
  - LOADING→LOADED when loaded_mask_out is all ones and the FIFO is empty.
  - copy_start_in in LOADING or LOADED restarts: clear mask, FIFO and overflow, then go to LOADING.
  - squash_in from any state: go to IDLE, clear mask (except bit 0), FIFO and overflow.
  - squash_in has priority over copy_start_in and over push.
- Read path, active only when is_master_in is 1:
  - rf_rd_addr_out = copy_read_addr_in, combinationally.
  - copy_data_out is registered: rf_rd_data_in sampled at the edge, or 0 if the address was 0 or is_master_in was 0.
  - The read path works in any FSM state.
- Write path:
  - Push when state is LOADING, copy_write_en_in=1 and copy_write_addr_in≠0. Writes to x0 are discarded silently.
  - A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the write is dropped and overflow_out is set.
  - Writes arriving in IDLE or LOADED are ignored and do not set overflow.
- Drain:
  - Pop when FIFO is non-empty and core_wb_busy_in=0.
  - rf_wr_en_out/addr/data are driven combinationally from the head entry during the pop cycle.
  - The mask bit for that register is set at the edge.
- Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit. Full means the indices match and the wrap bits differ; empty means both fields are equal.
- Duplicate writes to one register drain in order, so the last write wins.

## Timing
- Reset values: copy_data_out=0, rf_wr_en_out=0, fifo_full_out=0, overflow_out=0, loaded_mask_out=32'h1, context_loaded_out=0, state IDLE, FIFO empty.
- rf_wr_addr_out and rf_wr_data_out are 0 whenever rf_wr_en_out=0.
- Read latency: 1 cycle, address at cycle N → data at N+1. The STU may issue back-to-back addresses.
- Write latency with an empty FIFO and idle writeback: push at N → RF write at N+1 → mask bit visible at N+2.
- context_loaded_out rises the cycle after the final pop.
- copy_start_in and a write in the same cycle: the FIFO is cleared, then the write is pushed.
- Asynchronous reset mid-copy: FIFO contents are lost, and outputs return to reset values immediately.

## Test plan
- Read: is_master_in=1; RF x5=64'hDEAD_BEEF. Present addr 5 at N → copy_data_out=64'hDEAD_BEEF at N+1. Addr 0 → 0. With is_master_in=0 → 0.
- Full load: copy_start_in, then 31 writes x1..x31 with data=index, core_wb_busy_in=0 → 31 RF writes in order; loaded_mask_out=32'hFFFF_FFFF; context_loaded_out=1 one cycle after the last write.
- Backpressure:
  - Hold core_wb_busy_in=1 and push 5 writes → fifo_full_out after 4; the 5th is dropped; overflow_out=1.
  - Release busy → 4 RF writes on consecutive cycles.
- Full with simultaneous pop: FIFO full, busy drops the same cycle as a push → push accepted, overflow_out stays 0, count stays 4.
- Squash: mid-load with 3 queued entries, pulse squash_in → next cycle FIFO empty, mask=32'h1, state IDLE; following writes are ignored and no RF writes occur.
- Async reset: assert rst=0 mid-drain between clock edges → rf_wr_en_out=0 and all outputs at reset values before the next edge.

Source files
------------

// File: rtl/stu_copy_responder.sv
// stu_copy_responder: per-core endpoint of the STU context-copy bus.
// As master it serves register reads through a spare RF read port; as the
// speculative target it queues incoming register writes in a small FIFO and
// drains them into the RF write port whenever core writeback leaves it free.
module stu_copy_responder #(
  parameter int CORE_ID    = 0,
  parameter int XLEN       = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            copy_start_in,
  input  logic            squash_in,
  input  logic            is_master_in,
  input  logic [4:0]      copy_read_addr_in,
  output logic [XLEN-1:0] copy_data_out,
  input  logic [4:0]      copy_write_addr_in,
  input  logic            copy_write_en_in,
  input  logic [XLEN-1:0] copy_data_in,
  output logic [4:0]      rf_rd_addr_out,
  input  logic [XLEN-1:0] rf_rd_data_in,
  input  logic            core_wb_busy_in,
  output logic            rf_wr_en_out,
  output logic [4:0]      rf_wr_addr_out,
  output logic [XLEN-1:0] rf_wr_data_out,
  output logic            fifo_full_out,
  output logic            overflow_out,
  output logic [31:0]     loaded_mask_out,
  output logic            context_loaded_out
);

  localparam int IdxW = $clog2(FIFO_DEPTH);
  localparam int PtrW = IdxW + 1;

  // Elaboration guards: the wrap-bit pointer scheme needs a power-of-two depth.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("stu_copy_responder: FIFO_DEPTH must be a power of two >= 2");
  end
  if (CORE_ID < 0) begin : gBadCoreId
    $error("stu_copy_responder: CORE_ID must be non-negative");
  end

  typedef enum logic [1:0] {
    StIdle,
    StLoading,
    StLoaded
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
  logic [31:0]       mask_q, mask_d;
  logic              overflow_q, overflow_d;
  logic [XLEN-1:0]   copyData_q, copyData_d;

  logic [4:0]        fifoAddr_q [FIFO_DEPTH];
  logic [XLEN-1:0]   fifoData_q [FIFO_DEPTH];

  logic              fifoEmpty;
  logic              fifoFull;
  logic              clearAll;
  logic              pushReq;
  logic              pushAccept;
  logic              pushDrop;
  logic              popEn;
  logic [IdxW-1:0]   headIdx;
  logic [IdxW-1:0]   wrIdx;
  logic [4:0]        headAddr;
  logic [XLEN-1:0]   headData;

  // FIFO status, push/pop qualification; a squash or restart flushes the queue,
  // so nothing is drained in that cycle and a restart push lands in slot 0.
  always_comb begin
    fifoEmpty  = (wrPtr_q == rdPtr_q);
    fifoFull   = (wrPtr_q[IdxW-1:0] == rdPtr_q[IdxW-1:0]) &&
                 (wrPtr_q[IdxW] != rdPtr_q[IdxW]);
    clearAll   = squash_in | copy_start_in;
    pushReq    = copy_write_en_in && (copy_write_addr_in != 5'd0) && !squash_in &&
                 (copy_start_in || (state_q == StLoading));
    popEn      = !fifoEmpty && !core_wb_busy_in && !clearAll;
    pushAccept = pushReq && (copy_start_in || !fifoFull || popEn);
    pushDrop   = pushReq && !pushAccept;
    headIdx    = rdPtr_q[IdxW-1:0];
    wrIdx      = copy_start_in ? '0 : wrPtr_q[IdxW-1:0];
    headAddr   = fifoAddr_q[headIdx];
    headData   = fifoData_q[headIdx];
  end

  // Next pointers, loaded mask and sticky overflow flag.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    mask_d     = mask_q;
    overflow_d = overflow_q;
    if (clearAll) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      mask_d     = 32'h1;
      overflow_d = 1'b0;
    end else begin
      if (popEn) begin
        rdPtr_d          = rdPtr_q + PtrW'(1);
        mask_d[headAddr] = 1'b1;
      end
      if (pushDrop) begin
        overflow_d = 1'b1;
      end
    end
    if (pushAccept) begin
      wrPtr_d = (copy_start_in ? '0 : wrPtr_q) + PtrW'(1);
    end
    mask_d[0] = 1'b1;
  end

  // Next FSM state; LOADED is entered on the edge of the final pop so the
  // loaded flag rises the following cycle.
  always_comb begin
    state_d = state_q;
    if (squash_in) begin
      state_d = StIdle;
    end else if (copy_start_in) begin
      state_d = StLoading;
    end else if (state_q == StLoading && (&mask_d) && (wrPtr_d == rdPtr_d)) begin
      state_d = StLoaded;
    end
  end

  // Read data for the STU: zero unless a non-zero register was read as master.
  always_comb begin
    copyData_d = '0;
    if (is_master_in && copy_read_addr_in != 5'd0) begin
      copyData_d = rf_rd_data_in;
    end
  end

  // Control and status registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      mask_q     <= 32'h1;
      overflow_q <= 1'b0;
      copyData_q <= '0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
      copyData_q <= copyData_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (pushAccept) begin
      fifoAddr_q[wrIdx] <= copy_write_addr_in;
      fifoData_q[wrIdx] <= copy_data_in;
    end
  end

  // Output drive; the RF write port is zeroed when no pop is happening.
  always_comb begin
    rf_rd_addr_out     = is_master_in ? copy_read_addr_in : 5'd0;
    copy_data_out      = copyData_q;
    rf_wr_en_out       = popEn;
    rf_wr_addr_out     = popEn ? headAddr : 5'd0;
    rf_wr_data_out     = popEn ? headData : '0;
    fifo_full_out      = fifoFull;
    overflow_out       = overflow_q;
    loaded_mask_out    = mask_q;
    context_loaded_out = (state_q == StLoaded);
  end

endmodule
